mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised synchronous up/down counter, the next generation of the team's 4-bit enable counter. Adds configurable width and modulus, direction control, parallel load, synchronous clear, an enable prescaler, wrap or saturate mode, and boundary-event flags. Used as a general-purpose event/timebase counter in the step designs and their benches.

## Interface
Parameters:
- WIDTH, 4: counter width in bits; legal range 1..32.
- MODULUS, 16: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, 0: boundary mode; 0 = wrap, 1 = saturate (hold at bound).
- PRESCALE, 1: enabled cycles per count step; legal range 1..65535.

Ports:
- clock, input, 1: single clock; all state changes on posedge.
- reset, input, 1: synchronous, active-high; highest priority.
- enable, input, 1: advances the prescaler and counter when high.
- up_down, input, 1: direction; 1 = up, 0 = down. Sampled only on step cycles.
- load, input, 1: parallel load strobe.
- load_value, input, WIDTH: value loaded when load is high.
- clear, input, 1: synchronous clear of counter, prescaler and sticky flag.
- counter_out, output, WIDTH: current count, registered.
- limit, output, 1: registered one-cycle pulse marking a boundary event.
- limit_sticky, output, 1: set by any boundary event; held until clear or reset.

## Operation
- Priority per edge: reset > clear > load > count step > hold.
- reset or clear: counter_out = 0, prescaler = 0, limit = 0, limit_sticky = 0.
- load: counter_out = load_value, or MODULUS-1 if load_value >= MODULUS (clamped). Prescaler = 0. limit = 0. Sticky unchanged. enable is ignored that cycle.
- Prescaler: internal counter presc over 0..PRESCALE-1, width ceil(log2(PRESCALE)), minimum 1 bit.
  - enable high and presc < PRESCALE-1: presc increments and there is no step.
  - enable high and presc = PRESCALE-1: presc returns to 0 and a step occurs.
  - PRESCALE = 1: every enabled cycle is a step.
  - enable low: presc holds.
- Step, up:
  - count < MODULUS-1: count+1.
  - count = MODULUS-1: wrap mode goes to 0; saturate mode holds MODULUS-1. Both set the limit event.
- Step, down:
  - count > 0: count-1.
  - count = 0: wrap mode goes to MODULUS-1; saturate mode holds 0. Both set the limit event.
- Limit event: limit = 1 for exactly one cycle and limit_sticky = 1. In saturate mode, each further step at the bound repeats the event, so limit stays high on consecutive step cycles.
- Non-step cycles: limit = 0.
- Arithmetic is done in WIDTH+1 bits internally. counter_out never exceeds MODULUS-1, including when MODULUS = 2^WIDTH.
- Direction change mid-count takes effect on the next step. The prescaler phase is not reset.

## Timing
- All outputs are registered. Reset values: counter_out = 0, limit = 0, limit_sticky = 0.
- Latency: inputs sampled at edge k; counter_out, limit and limit_sticky reflect them after edge k. No combinational input-to-output paths.
- limit is high in the same cycle counter_out shows the wrapped or held value.
- Reset mid-count or mid-prescale: all state is 0 after that edge, regardless of load, clear or enable.
- load and clear together: clear wins.
- load with enable at presc = PRESCALE-1: the load wins and no step or limit occurs.
- clear on the same edge as a limit event: limit = 0 and limit_sticky = 0.

## Test plan
- Reset/basic, defaults: reset high 2 cycles, then enable high 20 cycles.
  - counter_out goes 0,1,…,15,0,1,2,3.
  - limit is high only in the cycle showing 0 after 15.
  - limit_sticky is 1 after that cycle.
- Down/wrap, MODULUS=10: load 2, up_down=0, enable 4 cycles.
  - counter_out goes 1,0,9,8.
  - limit pulses with 9.
- Saturate, SATURATE=1, MODULUS=10: load 8, up_down=1, enable 4 cycles.
  - counter_out goes 9,9,9,9.
  - limit is high on the last 3 of those cycles.
  - clear then gives counter_out = 0, limit_sticky = 0.
- Prescale, PRESCALE=3: enable high 9 cycles from reset.
  - counter_out steps only after enabled cycles 3, 6, 9, giving 1,2,3.
  - Dropping enable for 2 cycles mid-count delays the next step by 2 cycles.
- Load clamp/priority, WIDTH=4, MODULUS=12:
  - load_value=14 gives 11.
  - load and clear together give 0.
  - load and enable at presc boundary give load_value with no step and no limit.
- Reset mid-operation: assert reset while the counter is at 7, presc is mid-count and limit_sticky=1.
  - All outputs are 0 after that edge.
  - The first step after reset produces 1.

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulo counter with enable prescaler,
// parallel load with clamping, synchronous clear, wrap/saturate mode and
// boundary-event flags (one-cycle pulse plus sticky).
module mod_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int unsigned     SATURATE = 0,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic [WIDTH-1:0] counter_out,
    output logic             limit,
    output logic             limit_sticky
);

    localparam int unsigned     PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    // MODULUS may equal 2^WIDTH, so bound comparisons use one extra bit
    localparam logic [WIDTH:0]  MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]  MAX_EXT  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_next;
    logic             step;
    logic             bound_hit;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_clamped;

    // Prescaler advance, step value with boundary handling, load clamping
    always_comb begin
        step       = enable && (presc == PRE_LAST);
        presc_next = presc;
        if (enable) begin
            presc_next = step ? '0 : presc + 1'b1;
        end

        bound_hit  = 1'b0;
        count_next = counter_out;
        if (up_down) begin
            if ({1'b0, counter_out} >= MAX_EXT) begin
                bound_hit  = 1'b1;
                count_next = (SATURATE != 0) ? MAX_W : '0;
            end else begin
                count_next = counter_out + 1'b1;
            end
        end else begin
            if (counter_out == '0) begin
                bound_hit  = 1'b1;
                count_next = (SATURATE != 0) ? '0 : MAX_W;
            end else begin
                count_next = counter_out - 1'b1;
            end
        end

        load_clamped = load_value;
        if ({1'b0, load_value} >= MOD_EXT) begin
            load_clamped = MAX_W;
        end
    end

    // State update: reset > clear > load > step > hold
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            counter_out  <= '0;
            presc        <= '0;
            limit        <= 1'b0;
            limit_sticky <= 1'b0;
        end else if (load) begin
            counter_out  <= load_clamped;
            presc        <= '0;
            limit        <= 1'b0;
        end else if (step) begin
            counter_out  <= count_next;
            presc        <= presc_next;
            limit        <= bound_hit;
            limit_sticky <= limit_sticky | bound_hit;
        end else begin
            presc        <= presc_next;
            limit        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed scoreboard bench over five mod_counter
// configurations sharing one set of input stimulus.
module tb_mod_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] load_value;
    logic       clear;

    logic [3:0] co [5];
    logic       li [5];
    logic       ls [5];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] inst;
        logic [3:0] cnt;
        logic       lim;
        logic       stk;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];

    always #5 clock = ~clock;

    // 0: defaults
    mod_counter u0 (.clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .clear(clear),
        .counter_out(co[0]), .limit(li[0]), .limit_sticky(ls[0]));
    // 1: MODULUS=10 wrap
    mod_counter #(.WIDTH(4), .MODULUS(10)) u1 (.clock(clock), .reset(reset),
        .enable(enable), .up_down(up_down), .load(load), .load_value(load_value),
        .clear(clear), .counter_out(co[1]), .limit(li[1]), .limit_sticky(ls[1]));
    // 2: MODULUS=10 saturate
    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u2 (.clock(clock),
        .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .clear(clear), .counter_out(co[2]),
        .limit(li[2]), .limit_sticky(ls[2]));
    // 3: PRESCALE=3
    mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u3 (.clock(clock),
        .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .clear(clear), .counter_out(co[3]),
        .limit(li[3]), .limit_sticky(ls[3]));
    // 4: MODULUS=12, PRESCALE=2
    mod_counter #(.WIDTH(4), .MODULUS(12), .PRESCALE(2)) u4 (.clock(clock),
        .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .clear(clear), .counter_out(co[4]),
        .limit(li[4]), .limit_sticky(ls[4]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push expectation for the upcoming edge, then pop and compare after it
    task automatic cyc(input string tag, input int inst, input int c, input int l, input int s);
        exp_t e;
        string t;
        e.inst = 3'(inst);
        e.cnt  = 4'(c);
        e.lim  = 1'(l);
        e.stk  = 1'(s);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".cnt"},    32'(co[e.inst]), 32'(e.cnt));
        check({t, ".limit"},  32'(li[e.inst]), 32'(e.lim));
        check({t, ".sticky"}, 32'(ls[e.inst]), 32'(e.stk));
    endtask

    task automatic drive(input logic r, input logic en, input logic ud,
                         input logic ld, input logic [3:0] lv, input logic cl);
        reset = r; enable = en; up_down = ud; load = ld; load_value = lv; clear = cl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        drive(1, 0, 1, 0, 0, 0);
        #2;

        // Defaults: reset 2 cycles, then count up 20 cycles through wrap
        cyc("def_rst0", 0, 0, 0, 0);
        cyc("def_rst1", 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc($sformatf("def_up%0d", i), 0, i % 16, (i == 16) ? 1 : 0, (i >= 16) ? 1 : 0);
        end

        // MODULUS=10 down wrap from 2
        drive(1, 0, 1, 0, 0, 0);
        cyc("dn_rst", 1, 0, 0, 0);
        drive(0, 0, 0, 1, 4'd2, 0);
        cyc("dn_load", 1, 2, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        cyc("dn_1", 1, 1, 0, 0);
        cyc("dn_0", 1, 0, 0, 0);
        cyc("dn_9", 1, 9, 1, 1);
        cyc("dn_8", 1, 8, 0, 1);

        // Saturate at MODULUS-1, then clear
        drive(1, 0, 1, 0, 0, 0);
        cyc("sat_rst", 2, 0, 0, 0);
        drive(0, 0, 1, 1, 4'd8, 0);
        cyc("sat_load", 2, 8, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        cyc("sat_a", 2, 9, 0, 0);
        cyc("sat_b", 2, 9, 1, 1);
        cyc("sat_c", 2, 9, 1, 1);
        cyc("sat_d", 2, 9, 1, 1);
        drive(0, 0, 1, 0, 0, 1);
        cyc("sat_clr", 2, 0, 0, 0);

        // PRESCALE=3: step every third enabled cycle, pause delays
        drive(1, 0, 1, 0, 0, 0);
        cyc("pre_rst", 3, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc($sformatf("pre_en%0d", i), 3, i / 3, 0, 0);
        end
        cyc("pre_p1", 3, 3, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        cyc("pre_off1", 3, 3, 0, 0);
        cyc("pre_off2", 3, 3, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        cyc("pre_p2", 3, 3, 0, 0);
        cyc("pre_step4", 3, 4, 0, 0);

        // MODULUS=12 clamp and priority
        drive(1, 0, 1, 0, 0, 0);
        cyc("ld_rst", 4, 0, 0, 0);
        drive(0, 0, 1, 1, 4'd14, 0);
        cyc("ld_clamp", 4, 11, 0, 0);
        drive(0, 0, 1, 1, 4'd5, 1);
        cyc("ld_vs_clr", 4, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        cyc("ld_pre1", 4, 0, 0, 0);
        drive(0, 1, 1, 1, 4'd5, 0);
        cyc("ld_at_step", 4, 5, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        cyc("ld_pre_rst", 4, 5, 0, 0);
        cyc("ld_step6", 4, 6, 0, 0);
        drive(0, 0, 1, 1, 4'd11, 0);
        cyc("ld_11", 4, 11, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        cyc("wrap_pre", 4, 11, 0, 0);
        cyc("wrap_0", 4, 0, 1, 1);
        drive(0, 0, 1, 1, 4'd11, 0);
        cyc("ld_keep_stk", 4, 11, 0, 1);
        drive(0, 1, 1, 0, 0, 0);
        cyc("clr_pre", 4, 11, 0, 1);
        drive(0, 1, 1, 0, 0, 1);
        cyc("clr_vs_limit", 4, 0, 0, 0);

        // Reset mid-count with presc mid-way and sticky set
        drive(0, 0, 1, 1, 4'd15, 0);
        cyc("mid_ld15", 3, 15, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        cyc("mid_p1", 3, 15, 0, 0);
        cyc("mid_p2", 3, 15, 0, 0);
        cyc("mid_wrap", 3, 0, 1, 1);
        drive(0, 0, 1, 1, 4'd7, 0);
        cyc("mid_ld7", 3, 7, 0, 1);
        drive(0, 1, 1, 0, 0, 0);
        cyc("mid_pre", 3, 7, 0, 1);
        drive(1, 1, 1, 1, 4'd9, 0);
        cyc("mid_reset", 3, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        cyc("post_a", 3, 0, 0, 0);
        cyc("post_b", 3, 0, 0, 0);
        cyc("post_step", 3, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
